// File: rtl/leaf_inject_ctrl_pkg.sv
// Shared leaf packet layout and source identifiers.
// The extract side uses the same field offsets.
package leaf_inject_ctrl_pkg;

  localparam int DEF_PACKET_BITS = 97;
  localparam int DEF_FIFO_DEPTH  = 4;
  localparam int NUM_LEAF_BITS   = 6;
  localparam int NUM_PORT_BITS   = 4;

  localparam int VLD_BIT = DEF_PACKET_BITS - 1;
  localparam int LEAF_HI = VLD_BIT - 1;
  localparam int LEAF_LO = LEAF_HI - NUM_LEAF_BITS + 1;
  localparam int PORT_HI = LEAF_LO - 1;
  localparam int PORT_LO = PORT_HI - NUM_PORT_BITS + 1;

  localparam int INPUT_PORT_MAX_NUM  = 8;
  localparam int OUTPUT_PORT_MIN_NUM = 9;

  typedef enum logic {
    SRC_CONFIG = 1'b0,
    SRC_STREAM = 1'b1
  } src_e;

endpackage

// File: rtl/leaf_inject_ctrl_fifo.sv
// Small per-source packet FIFO: register array, wrap-around pointers.
// A push at full is only taken when a pop happens on the same edge.
module leaf_pkt_fifo #(
  parameter int PACKET_BITS = 97,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [PACKET_BITS-1:0]       din,
  output logic [PACKET_BITS-1:0]       head,
  output logic [$clog2(FIFO_DEPTH):0]  count,
  output logic                         empty
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = AW + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [PACKET_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PACKET_BITS-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != DEPTH_C) || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);

endmodule

// File: rtl/leaf_inject_ctrl.sv
// Merges stream and config packets onto the leaf-to-BFT output with
// round-robin arbitration, resend stall handling and per-source buffering.
module leaf_inject_ctrl
  import leaf_inject_ctrl_pkg::*;
#(
  parameter int PACKET_BITS = DEF_PACKET_BITS,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [PACKET_BITS-1:0] stream_in,
  output logic                   stream_full,
  input  logic [PACKET_BITS-1:0] config_in,
  output logic                   config_full,
  input  logic                   resend,
  output logic [PACKET_BITS-1:0] dout_leaf_interface2bft,
  output logic                   overflow,
  output logic [15:0]            resend_cnt
);

  localparam int VLD   = PACKET_BITS - 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] FULL_C  = CNT_W'(FIFO_DEPTH - 1);

  logic [PACKET_BITS-1:0] s_head, c_head;
  logic [CNT_W-1:0]       s_count, c_count;
  logic                   s_empty, c_empty;
  logic                   s_push, c_push, s_pop, c_pop;
  logic                   out_free;

  logic [PACKET_BITS-1:0] dout_q, dout_d;
  src_e                   rr_q, rr_d;
  logic                   overflow_q, overflow_d;
  logic [15:0]            resend_cnt_q, resend_cnt_d;

  leaf_pkt_fifo #(.PACKET_BITS(PACKET_BITS), .FIFO_DEPTH(FIFO_DEPTH)) u_stream_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (s_push),
    .pop   (s_pop),
    .din   (stream_in),
    .head  (s_head),
    .count (s_count),
    .empty (s_empty)
  );

  leaf_pkt_fifo #(.PACKET_BITS(PACKET_BITS), .FIFO_DEPTH(FIFO_DEPTH)) u_config_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (c_push),
    .pop   (c_pop),
    .din   (config_in),
    .head  (c_head),
    .count (c_count),
    .empty (c_empty)
  );

  // rr_q names the source that wins the next tie.
  always_comb begin
    out_free = !dout_q[VLD] || !resend;
    c_pop    = out_free && !c_empty && (s_empty || (rr_q == SRC_CONFIG));
    s_pop    = out_free && !s_empty && (c_empty || (rr_q == SRC_STREAM));
    s_push   = stream_in[VLD] && ((s_count != DEPTH_C) || s_pop);
    c_push   = config_in[VLD] && ((c_count != DEPTH_C) || c_pop);

    dout_d = dout_q;
    rr_d   = rr_q;
    if (out_free) begin
      if (c_pop) begin
        dout_d = c_head;
        rr_d   = SRC_STREAM;
      end else if (s_pop) begin
        dout_d = s_head;
        rr_d   = SRC_CONFIG;
      end else begin
        dout_d = '0;
      end
    end

    overflow_d = overflow_q
               | (stream_in[VLD] & ~s_push)
               | (config_in[VLD] & ~c_push);

    resend_cnt_d = resend_cnt_q;
    if (dout_q[VLD] && resend && (resend_cnt_q != 16'hFFFF)) begin
      resend_cnt_d = resend_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dout_q       <= '0;
      rr_q         <= SRC_CONFIG;
      overflow_q   <= 1'b0;
      resend_cnt_q <= '0;
    end else begin
      dout_q       <= dout_d;
      rr_q         <= rr_d;
      overflow_q   <= overflow_d;
      resend_cnt_q <= resend_cnt_d;
    end
  end

  assign stream_full             = (s_count >= FULL_C);
  assign config_full             = (c_count >= FULL_C);
  assign dout_leaf_interface2bft = dout_q;
  assign overflow                = overflow_q;
  assign resend_cnt              = resend_cnt_q;

endmodule
